alu_ctrl_pipe: RTL and testbench

//  Parametrised, registered successor to the combinational ALU control decoder. Maps {alu_op, opcode}
//  to alu_cnt plus ext/illegal flags behind valid/ready handshakes, adds a multi-cycle extended-op

---
 rtl/alu_ctrl_pipe_if.sv | 27 ++
 rtl/alu_ctrl_pipe.sv | 86 ++++++++
 tb/tb_alu_ctrl_pipe.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: decode-side request and execute-side result handshakes for the ALU control stage
interface alu_ctrl_pipe_if #(
    parameter int ALUOP_W  = 2,
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [ALUOP_W-1:0]  alu_op;
    logic [OPCODE_W-1:0] opcode;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    alu_cnt;
    logic                alu_ext;
    logic                illegal;
    logic                mc_busy;

    modport master (
        output in_valid, alu_op, opcode, out_ready,
        input  in_ready, out_valid, alu_cnt, alu_ext, illegal, mc_busy
    );

    modport slave (
        input  in_valid, alu_op, opcode, out_ready,
        output in_ready, out_valid, alu_cnt, alu_ext, illegal, mc_busy
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU control decoder with multi-cycle extended ops and flush
module alu_ctrl_pipe #(
    parameter int ALUOP_W   = 2,
    parameter int OPCODE_W  = 4,
    parameter int CNT_W     = 3,
    parameter int R_BASE    = 2,
    parameter int MC_CYCLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush,
    alu_ctrl_pipe_if.slave  bus
);
    localparam int CTR_W = MC_CYCLES > 1 ? $clog2(MC_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MC_WAIT, VALID} state_t;

    state_t              state;
    logic [CTR_W-1:0]    ctr;
    logic [ALUOP_W-1:0]  op_full;
    logic [1:0]          op;
    logic [OPCODE_W-1:0] diff;
    logic                in_r;
    logic                ext_hi;
    logic                d_ext;
    logic                d_ill;
    logic                d_mc;
    logic [CNT_W-1:0]    d_cnt;
    logic                accept;

    assign op_full      = bus.alu_op;
    assign op           = op_full[1:0];
    assign bus.in_ready = (state == IDLE) || (state == VALID && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // decode the offered op; only the accept edge samples these
    always_comb begin
        diff   = bus.opcode - OPCODE_W'(R_BASE);
        in_r   = int'(bus.opcode) >= R_BASE && int'(bus.opcode) < R_BASE + (1 << CNT_W);
        ext_hi = int'(bus.opcode) >= (1 << CNT_W);
        d_ext  = op == 2'b11;
        d_ill  = d_ext ? ext_hi : (op == 2'b00 && !in_r);
        d_mc   = d_ext && !ext_hi;
        d_cnt  = op == 2'b10 ? '0 :
                 op == 2'b01 ? CNT_W'(1) :
                 op == 2'b11 ? bus.opcode[CNT_W-1:0] :
                 in_r        ? diff[CNT_W-1:0] : '0;
    end

    // handshake FSM with registered result, stall counter and flush abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ctr           <= '0;
            bus.out_valid <= 1'b0;
            bus.mc_busy   <= 1'b0;
            bus.alu_cnt   <= '0;
            bus.alu_ext   <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            ctr           <= '0;
            bus.out_valid <= 1'b0;
            bus.mc_busy   <= 1'b0;
        end else if (accept) begin
            bus.alu_cnt   <= d_cnt;
            bus.alu_ext   <= d_ext;
            bus.illegal   <= d_ill;
            state         <= d_mc ? MC_WAIT : VALID;
            ctr           <= d_mc ? CTR_W'(MC_CYCLES - 1) : '0;
            bus.mc_busy   <= d_mc;
            bus.out_valid <= !d_mc;
        end else if (state == MC_WAIT) begin
            if (ctr == '0) begin
                state         <= VALID;
                bus.mc_busy   <= 1'b0;
                bus.out_valid <= 1'b1;
            end else begin
                ctr <= ctr - 1'b1;
            end
        end else if (state == VALID && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed scenarios plus a randomized scoreboard run for alu_ctrl_pipe
module tb_alu_ctrl_pipe;
    localparam int R_BASE = 2;
    localparam int NCNT   = 8;
    localparam int MC     = 4;

    typedef struct {
        int cnt;
        bit ext;
        bit ill;
        bit mc;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    alu_ctrl_pipe_if #(.ALUOP_W(2), .OPCODE_W(4), .CNT_W(3)) bus ();

    alu_ctrl_pipe #(.ALUOP_W(2), .OPCODE_W(4), .CNT_W(3), .R_BASE(R_BASE), .MC_CYCLES(MC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference decode straight from the class rules
    function automatic exp_t ref_dec(input int op, input int opc);
        exp_t e;
        e.ext = op == 3;
        e.ill = 1'b0;
        e.cnt = 0;
        e.due = 0;
        if (op == 2) e.cnt = 0;
        else if (op == 1) e.cnt = 1;
        else if (op == 3) begin
            e.cnt = opc % NCNT;
            e.ill = opc >= NCNT;
        end else if (opc >= R_BASE && opc < R_BASE + NCNT) e.cnt = opc - R_BASE;
        else e.ill = 1'b1;
        e.mc = e.ext && !e.ill;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int op, input int opc);
        bus.in_valid = v;
        bus.alu_op   = 2'(op);
        bus.opcode   = 4'(opc);
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        drive(0, 0, 0);
        tick();
        tick();
        compared++;
        if ({bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy});
        end
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive(1, 0, 4);
        #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL single_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        drive(0, 0, 0);
        compared++;
        if ({bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL single_result: got %b expected 1010_0_0",
                     {bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal});
        end
        tick();
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_drain: out_valid %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_stream();
        for (int opc = 2; opc <= 10; opc++) begin
            exp_t e;
            e = ref_dec(0, opc);
            drive(1, 0, opc);
            #1;
            compared++;
            if (bus.in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL stream_in_ready opc=%0d: got %b expected 1", opc, bus.in_ready);
            end
            tick();
            compared++;
            if ({bus.out_valid, bus.alu_cnt, bus.illegal} !== {1'b1, 3'(e.cnt), e.ill}) begin
                mismatched++;
                $display("FAIL stream_result opc=%0d: got v=%b cnt=%0d ill=%b expected v=1 cnt=%0d ill=%b",
                         opc, bus.out_valid, bus.alu_cnt, bus.illegal, e.cnt, e.ill);
            end
        end
        drive(0, 0, 0);
        tick();
    endtask

    task automatic test_ext();
        drive(1, 3, 5);
        tick();
        drive(0, 0, 0);
        for (int i = 1; i <= MC; i++) begin
            #1;
            compared++;
            if ({bus.mc_busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
                mismatched++;
                $display("FAIL ext_stall cycle %0d: busy/in_ready/out_valid %b expected 100", i,
                         {bus.mc_busy, bus.in_ready, bus.out_valid});
            end
            tick();
        end
        compared++;
        if ({bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy} !== {1'b1, 3'd5, 1'b1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL ext_result: got %b expected 1101_1_0_0",
                     {bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy});
        end
        tick();
        drive(1, 3, 12);
        tick();
        drive(0, 0, 0);
        compared++;
        if ({bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy} !== {1'b1, 3'd4, 1'b1, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL ext_illegal: got %b expected 1100_1_1_0",
                     {bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy});
        end
        tick();
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        drive(1, 0, 7);
        tick();
        drive(1, 1, 9);
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if ({bus.in_ready, bus.out_valid, bus.alu_cnt, bus.illegal} !== {1'b0, 1'b1, 3'd5, 1'b0}) begin
                mismatched++;
                $display("FAIL hold cycle %0d: in_ready/v/cnt/ill %b expected 0_1_101_0", i,
                         {bus.in_ready, bus.out_valid, bus.alu_cnt, bus.illegal});
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL hold_release_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        drive(0, 0, 0);
        compared++;
        if ({bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL hold_next_op: got %b expected 1001_0_0",
                     {bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal});
        end
        tick();
    endtask

    task automatic test_flush();
        int seen;
        drive(1, 3, 5);
        tick();
        drive(0, 0, 0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        compared++;
        if ({bus.out_valid, bus.mc_busy, bus.in_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL flush_mc: v/busy/in_ready %b expected 001",
                     {bus.out_valid, bus.mc_busy, bus.in_ready});
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL flush_no_emit: out_valid cycles %0d expected 0", seen);
        end
        drive(1, 0, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 0, 0);
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_idle_drop: out_valid %b expected 0", bus.out_valid);
        end
        tick();
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_idle_late: out_valid %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 3, 6);
        tick();
        drive(0, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy} !== 7'b0) begin
            mismatched++;
            $display("FAIL async_reset_outputs: got %b expected 0000000",
                     {bus.out_valid, bus.alu_cnt, bus.alu_ext, bus.illegal, bus.mc_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        compared++;
        if ({bus.in_ready, bus.out_valid, bus.mc_busy} !== 3'b100) begin
            mismatched++;
            $display("FAIL async_reset_idle: in_ready/v/busy %b expected 100",
                     {bus.in_ready, bus.out_valid, bus.mc_busy});
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        int   cyc;
        bit   exp_v;
        bit   exp_rdy;
        bit   exp_busy;
        cyc = 0;
        for (int n = 0; n < 600; n++) begin
            exp_t e;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 15));
            bus.out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 31) == 0;
            #1;
            exp_v    = q.size() > 0 && cyc >= q[0].due;
            exp_busy = q.size() > 0 && q[0].mc && cyc < q[0].due;
            exp_rdy  = q.size() == 0 || (exp_v && bus.out_ready);
            compared++;
            if ({bus.out_valid, bus.mc_busy, bus.in_ready} !== {exp_v, exp_busy, exp_rdy}) begin
                mismatched++;
                $display("FAIL rand_ctrl cyc=%0d: v/busy/in_ready %b expected %b", cyc,
                         {bus.out_valid, bus.mc_busy, bus.in_ready}, {exp_v, exp_busy, exp_rdy});
            end
            if (exp_v) begin
                compared++;
                if ({bus.alu_cnt, bus.alu_ext, bus.illegal} !== {3'(q[0].cnt), q[0].ext, q[0].ill}) begin
                    mismatched++;
                    $display("FAIL rand_data cyc=%0d: cnt=%0d ext=%b ill=%b expected cnt=%0d ext=%b ill=%b",
                             cyc, bus.alu_cnt, bus.alu_ext, bus.illegal, q[0].cnt, q[0].ext, q[0].ill);
                end
            end
            if (flush) q.delete();
            else begin
                if (exp_v && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && exp_rdy) begin
                    e = ref_dec(int'(bus.alu_op), int'(bus.opcode));
                    e.due = cyc + (e.mc ? MC + 1 : 1);
                    q.push_back(e);
                end
            end
            tick();
            cyc++;
        end
        flush = 1'b0;
        drive(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_ext();
        test_hold();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
